// File: rtl/disp_scan_ctrl.sv
// Display scan controller: rotates the digit select, drives the active-low anodes and commits staged frames only at frame wrap.
// Build option DISP_LZ_BLANK_EN: when defined, leading zeros are blanked at commit.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] num_in_i,
    input  logic [3:0]  dp_in_i,
    input  logic [3:0]  err_in_i,
    output logic        ready_o,
    output logic [3:0]  num0_o,
    output logic [3:0]  num1_o,
    output logic [3:0]  num2_o,
    output logic [3:0]  num3_o,
    output logic [3:0]  dp_o,
    output logic [3:0]  err_o,
    output logic [3:0]  blank_o,
    output logic [3:0]  sel_o,
    output logic [3:0]  an_o,
    output logic        frame_tick_o
);

    // state      | meaning
    // ST_EMPTY   | staging buffer free, load accepted
    // ST_PENDING | staged frame waiting for the next frame wrap
    typedef enum logic {ST_EMPTY = 1'b0, ST_PENDING = 1'b1} state_t;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TC_C   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYCLES);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    sel_q;
    logic          ready_q;
    logic          frame_tick_q;
    logic [15:0]   num_q;
    logic [3:0]    dp_q;
    logic [3:0]    err_q;
    logic [3:0]    blank_q;
    logic [15:0]   stg_num_q;
    logic [3:0]    stg_dp_q;
    logic [3:0]    stg_err_q;
    logic [3:0]    blank_d;
    logic          tc;
    logic          frame_wrap;

    assign tc         = (cnt_q == TC_C);
    assign frame_wrap = enable_i && tc && (sel_q == 4'b1000);

`ifdef DISP_LZ_BLANK_EN
    logic [3:0] lz;
    // A digit is a leading zero only if every more significant digit is one too.
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (stg_num_q[15:12] == 4'h0) && !stg_dp_q[3];
        lz[2] = lz[3] && (stg_num_q[11:8] == 4'h0) && !stg_dp_q[2];
        lz[1] = lz[2] && (stg_num_q[7:4] == 4'h0) && !stg_dp_q[1];
        blank_d = lz & ~stg_err_q;
    end
`else
    always_comb begin
        blank_d = 4'b0000;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_EMPTY;
            cnt_q        <= '0;
            sel_q        <= 4'b0001;
            ready_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            num_q        <= 16'h0000;
            dp_q         <= 4'b0000;
            err_q        <= 4'b0000;
            blank_q      <= 4'b0000;
            stg_num_q    <= 16'h0000;
            stg_dp_q     <= 4'b0000;
            stg_err_q    <= 4'b0000;
        end else begin
            frame_tick_q <= frame_wrap;
            if (enable_i) begin
                if (tc) begin
                    cnt_q <= '0;
                    sel_q <= {sel_q[2:0], sel_q[3]};
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            case (state_q)
                ST_EMPTY: begin
                    if (load_i) begin
                        stg_num_q <= num_in_i;
                        stg_dp_q  <= dp_in_i;
                        stg_err_q <= err_in_i;
                        ready_q   <= 1'b0;
                        state_q   <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (frame_wrap) begin
                        num_q   <= stg_num_q;
                        dp_q    <= stg_dp_q;
                        err_q   <= stg_err_q;
                        blank_q <= blank_d;
                        ready_q <= 1'b1;
                        state_q <= ST_EMPTY;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign an_o         = (!enable_i || (cnt_q < DEAD_C)) ? 4'b1111 : ~sel_q;
    assign sel_o        = sel_q;
    assign ready_o      = ready_q;
    assign frame_tick_o = frame_tick_q;
    assign num0_o       = num_q[3:0];
    assign num1_o       = num_q[7:4];
    assign num2_o       = num_q[11:8];
    assign num3_o       = num_q[15:12];
    assign dp_o         = dp_q;
    assign err_o        = err_q;
    assign blank_o      = blank_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with an 8-cycle slot and 2 dead cycles.
module tb_disp_scan_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, enable_i, load_i;
    logic [15:0] num_in_i;
    logic [3:0]  dp_in_i, err_in_i;
    logic        ready_o, frame_tick_o;
    logic [3:0]  num0_o, num1_o, num2_o, num3_o;
    logic [3:0]  dp_o, err_o, blank_o, sel_o, an_o;

    int checks = 0;
    int errors = 0;

`ifdef DISP_LZ_BLANK_EN
    localparam logic [3:0] BLK_0050 = 4'b1100;
    localparam logic [3:0] BLK_ERR3 = 4'b0110;
    localparam logic [3:0] BLK_0000 = 4'b1110;
`else
    localparam logic [3:0] BLK_0050 = 4'b0000;
    localparam logic [3:0] BLK_ERR3 = 4'b0000;
    localparam logic [3:0] BLK_0000 = 4'b0000;
`endif

    disp_scan_ctrl #(.REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .load_i(load_i),
        .num_in_i(num_in_i), .dp_in_i(dp_in_i), .err_in_i(err_in_i),
        .ready_o(ready_o), .num0_o(num0_o), .num1_o(num1_o), .num2_o(num2_o),
        .num3_o(num3_o), .dp_o(dp_o), .err_o(err_o), .blank_o(blank_o),
        .sel_o(sel_o), .an_o(an_o), .frame_tick_o(frame_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; load_i = 1'b0;
        num_in_i = 16'h0; dp_in_i = 4'h0; err_in_i = 4'h0;
        cyc(3);
        rst_i = 1'b0;
        #1;
        chk("rst_sel", sel_o, 4'b0001);
        chk("rst_an", an_o, 4'b1111);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_tick", frame_tick_o, 1'b0);
        chk("rst_num", {num3_o, num2_o, num1_o, num0_o}, 16'h0000);
        chk("rst_flags", {dp_o, err_o, blank_o}, 12'h000);

        // scan rotation; k counts enabled edges
        enable_i = 1'b1;
        #1;  chk("k0_an", an_o, 4'b1111);
        cyc(1); chk("k1_an", an_o, 4'b1111);
        cyc(1); chk("k2_an", an_o, 4'b1110);
                chk("k2_sel", sel_o, 4'b0001);
        cyc(5); chk("k7_an", an_o, 4'b1110);
        cyc(1); chk("k8_sel", sel_o, 4'b0010);
                chk("k8_an", an_o, 4'b1111);
        cyc(2); chk("k10_an", an_o, 4'b1101);
        cyc(8); chk("k18_sel", sel_o, 4'b0100);
                chk("k18_an", an_o, 4'b1011);
        cyc(8); chk("k26_sel", sel_o, 4'b1000);
                chk("k26_an", an_o, 4'b0111);
        cyc(5); chk("k31_tick", frame_tick_o, 1'b0);
        cyc(1); chk("k32_tick", frame_tick_o, 1'b1);
                chk("k32_sel", sel_o, 4'b0001);
                chk("k32_ready", ready_o, 1'b1);
        cyc(1); chk("k33_tick", frame_tick_o, 1'b0);

        // load mid-frame, then a second load while pending
        cyc(4);
        load_i = 1'b1; num_in_i = 16'h1234; dp_in_i = 4'b0010; err_in_i = 4'b0000;
        cyc(1); load_i = 1'b0;
        chk("ld_ready0", ready_o, 1'b0);
        chk("ld_num_hold", {num3_o, num2_o, num1_o, num0_o}, 16'h0000);
        cyc(2);
        load_i = 1'b1; num_in_i = 16'hFFFF; dp_in_i = 4'b1111; err_in_i = 4'b1111;
        cyc(1); load_i = 1'b0; num_in_i = 16'h0; dp_in_i = 4'h0; err_in_i = 4'h0;
        chk("ld2_ready", ready_o, 1'b0);
        cyc(22);
        chk("k63_num", {num3_o, num2_o, num1_o, num0_o}, 16'h0000);
        chk("k63_ready", ready_o, 1'b0);
        cyc(1);
        chk("k64_tick", frame_tick_o, 1'b1);
        chk("k64_num3", num3_o, 4'h1);
        chk("k64_num2", num2_o, 4'h2);
        chk("k64_num1", num1_o, 4'h3);
        chk("k64_num0", num0_o, 4'h4);
        chk("k64_dp", dp_o, 4'b0010);
        chk("k64_err", err_o, 4'b0000);
        chk("k64_blank", blank_o, 4'b0000);
        chk("k64_ready", ready_o, 1'b1);

        // enable low at cnt=5 for 10 cycles
        cyc(5);
        enable_i = 1'b0;
        #1; chk("en0_an", an_o, 4'b1111);
        cyc(10);
        chk("en0_sel", sel_o, 4'b0001);
        chk("en0_an_hold", an_o, 4'b1111);
        enable_i = 1'b1;
        #1; chk("en1_an", an_o, 4'b1110);
        cyc(2); chk("en1_c7_sel", sel_o, 4'b0001);
        cyc(1); chk("en1_wrap_sel", sel_o, 4'b0010);
                chk("en1_wrap_an", an_o, 4'b1111);

        // leading-zero blanking: 0050
        load_i = 1'b1; num_in_i = 16'h0050;
        cyc(1); load_i = 1'b0;
        cyc(23);
        chk("lz0050_tick", frame_tick_o, 1'b1);
        chk("lz0050_num1", num1_o, 4'h5);
        chk("lz0050_blank", blank_o, BLK_0050);
        chk("lz0050_ready", ready_o, 1'b1);

        // 0000 with err on digit 3
        load_i = 1'b1; num_in_i = 16'h0000; err_in_i = 4'b1000;
        cyc(1); load_i = 1'b0; err_in_i = 4'b0000;
        cyc(31);
        chk("lzerr_tick", frame_tick_o, 1'b1);
        chk("lzerr_err", err_o, 4'b1000);
        chk("lzerr_blank", blank_o, BLK_ERR3);

        // load landing on the wrap edge: captured, not committed
        cyc(31);
        load_i = 1'b1; num_in_i = 16'h0000;
        cyc(1); load_i = 1'b0;
        chk("wrapld_tick", frame_tick_o, 1'b1);
        chk("wrapld_err", err_o, 4'b1000);
        chk("wrapld_blank", blank_o, BLK_ERR3);
        chk("wrapld_ready", ready_o, 1'b0);
        cyc(32);
        chk("lz0000_tick", frame_tick_o, 1'b1);
        chk("lz0000_err", err_o, 4'b0000);
        chk("lz0000_blank", blank_o, BLK_0000);
        chk("lz0000_ready", ready_o, 1'b1);

        // nonzero frame before reset test
        load_i = 1'b1; num_in_i = 16'h8765; dp_in_i = 4'b0001;
        cyc(1); load_i = 1'b0; dp_in_i = 4'b0000;
        cyc(31);
        chk("f8765_num3", num3_o, 4'h8);
        chk("f8765_num0", num0_o, 4'h5);
        chk("f8765_dp", dp_o, 4'b0001);

        // reset mid-slot with a frame pending
        load_i = 1'b1; num_in_i = 16'h9999;
        cyc(1); load_i = 1'b0;
        chk("pre_rst_ready", ready_o, 1'b0);
        cyc(11);
        chk("pre_rst_sel", sel_o, 4'b0010);
        rst_i = 1'b1;
        #1;
        chk("mrst_sel", sel_o, 4'b0001);
        chk("mrst_an", an_o, 4'b1111);
        chk("mrst_ready", ready_o, 1'b1);
        chk("mrst_num", {num3_o, num2_o, num1_o, num0_o}, 16'h0000);
        chk("mrst_dp", dp_o, 4'b0000);
        cyc(2);
        chk("mrst_hold_sel", sel_o, 4'b0001);
        rst_i = 1'b0;
        cyc(32);
        chk("post_rst_tick", frame_tick_o, 1'b1);
        chk("post_rst_num", {num3_o, num2_o, num1_o, num0_o}, 16'h0000);
        chk("post_rst_ready", ready_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexing controller for the 4-digit seven-segment display. Generates the one-hot digit select that drives the digit multiplexer's `S` input and the active-low anode lines, and holds the committed display frame (digits, decimal points, error and blank flags) feeding the multiplexer's per-digit inputs. New frames are staged via a ready/load handshake and committed only at a frame boundary, so a scan never shows a mix of old and new digits. It sits between the calculator result/formatting logic and the digit mux / segment decoder.

## Interface
- `REFRESH_DIV`, 50000, clock cycles per digit slot (1 ms at 50 MHz); must be ≥ 2
- `DEAD_CYCLES`, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be < `REFRESH_DIV`

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `enable`  in  1  scan enable; 0 freezes scanning and blanks anodes
- `load`  in  1  stage request; accepted only when `ready`=1
- `num_in`  in  16  digits, [15:12]=digit3 (MSD) … [3:0]=digit0
- `dp_in`  in  4  decimal points, bit i = digit i
- `err_in`  in  4  error flags, bit i = digit i
- `ready`  out  1  staging buffer empty
- `num0`..`num3`  out  4 each  committed digit values
- `dp`, `err`, `blank`  out  4 each  committed per-digit flags, bit i = digit i
- `sel`  out  4  one-hot digit select to the mux `S`
- `an`  out  4  anode drive, active-low
- `frame_tick`  out  1  one-cycle pulse at frame commit

## Operation
- Prescaler `cnt` counts 0..`REFRESH_DIV`-1, then wraps to 0. Width is `$clog2(REFRESH_DIV)`.
- At terminal count, `sel` rotates left: 0001→0010→0100→1000→0001. `sel` is never zero and never has multiple bits set.
- `an` = 4'b1111 when `enable`=0 or `cnt` < `DEAD_CYCLES`; otherwise `an` = ~`sel`. `an` is a combinational decode of registered state.
- Frame wrap is the terminal count while `sel`=1000. On that edge, if `pending`=1:
  - staging is copied to `num*`, `dp`, `err`, `blank`;
  - `pending` clears and `ready` returns to 1.
  - `frame_tick` pulses on the same edge whether or not a commit occurs.
- Handshake:
  - On `load`=1 with `ready`=1, `num_in`/`dp_in`/`err_in` are captured into staging; `pending`=1 and `ready`=0 on the next cycle.
  - `load` while `ready`=0 is ignored and the staging buffer is unchanged.
  - `load` on the wrap edge with `ready`=1: nothing is pending, so there is no commit; the load is captured normally.
- `enable`=0:
  - `cnt` and `sel` hold; no wrap, no commit, no `frame_tick`.
  - The handshake still accepts one load.
  - When `enable` returns to 1, counting resumes from the held `cnt`.
- Reset (asynchronous, any time, including mid-slot or with a frame pending):
  - `cnt`=0, `sel`=0001, `num0..3`=0, `dp`=`err`=`blank`=0000.
  - `pending`=0, `ready`=1, `frame_tick`=0, so `an`=1111 during the first slot's dead time.
  - Staged data is discarded.

## Timing
- Slot length is exactly `REFRESH_DIV` cycles; frame length is 4×`REFRESH_DIV`.
- Within each slot, `an` is active for `REFRESH_DIV`−`DEAD_CYCLES` cycles.
- `frame_tick` is high in the cycle where `sel`=0001 and `cnt`=0 after a wrap. Committed outputs are already valid in that cycle.
- Latency from load acceptance to visible data ranges from 1 cycle (accepted on the cycle before the wrap edge) to 4×`REFRESH_DIV` cycles.
- Every output and state bit is registered except `an`.

## Configuration
- `DISP_LZ_BLANK_EN` defined: at commit, `blank` is computed for leading zeros.
  - Digit i (i=3..1) is blanked if it and all more-significant digits are 0 and `dp` is 0 on each of those digits.
  - Digit 0 is never blanked.
  - `err` on a digit overrides blanking for that digit.
- Undefined: `blank` is always loaded as 0000 at commit.
- Reset value is 0000 in both builds.

## Test plan
All scenarios use `REFRESH_DIV`=8, `DEAD_CYCLES`=2.

1. **Reset, then `enable`=1:**
   - `sel` steps 0001,0010,0100,1000 every 8 cycles.
   - `an` is 1111 for 2 cycles, then 1110 (then 1101, 1011, 0111 in later slots).
   - `frame_tick` pulses every 32 cycles; `ready`=1.
2. **Load mid-frame:** `load` with `num_in`=16'h1234, `dp_in`=0010 at cycle 5.
   - `ready`=0 from cycle 6.
   - `num*` stays 0 until the wrap; then `num3`..`num0`=1,2,3,4, `dp`=0010, `frame_tick`=1, and `ready`=1.
3. **Second load while pending:** a second `load` with 16'hFFFF while `ready`=0 is ignored; 16'h1234 is committed.
4. **Enable low:** `enable`=0 at `cnt`=5, held 10 cycles.
   - `an`=1111 and `sel`/`cnt` frozen.
   - After release, the slot finishes in 3 more cycles.
5. **Leading-zero blanking:**
   - With `DISP_LZ_BLANK_EN`: 16'h0050 → `blank`=1100; 16'h0000 → 1110; 16'h0000 with `err_in`=1000 → 0110.
   - Without the macro: all give 0000.
6. **Reset mid-operation:** assert `rst` mid-slot with a frame pending.
   - All outputs go to reset values immediately and `ready`=1.
   - The pending frame is never committed.
